// File: rtl/id_operand_stage.sv
// id_operand_stage: decode/operand stage between instruction fetch and EX.
// It owns the 32-entry register file and decodes the fetched instruction.
// It selects the rs/rt operands, with mem-stage load forwarding on code 2.
// It then registers a single operand bundle for EX.
//
// Opcode encodings used by this stage:
//   STALL = 6'h3F, LDW = 6'h23, SDW = 6'h2B, BEQ = 6'h04, JUMP = 6'h02.
//   Every other opcode is treated as a register-type instruction.
//
// Optional feature macro: ID_WB_BYPASS_EN.
//   Defined: a writeback in the same cycle as the read of that register
//   supplies the operand value directly.
//   Undefined: the operand is the old RF value.
module id_operand_stage #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_in,
   input  logic [31:0]       pc_in,
   input  logic [2:0]        ld_rs,
   input  logic [2:0]        ld_rt,
   input  logic [DATA_W-1:0] mem_ld_data,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_kill,
   output logic              ex_valid,
   output logic [5:0]        ex_opcode,
   output logic [4:0]        ex_rwd,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [31:0]       ex_pc
);

   localparam logic [5:0] OP_STALL = 6'h3F;
   localparam logic [5:0] OP_LDW   = 6'h23;
   localparam logic [5:0] OP_SDW   = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_JUMP  = 6'h02;
   localparam logic [2:0] LD_FWD_MEM = 3'd2;

   logic [DATA_W-1:0] rf [32];

   logic [5:0]               opcode_p0;
   logic                     bubble_p0;
   logic                     no_rwd_p0;
   logic                     rt_hi_p0;
   logic [4:0]               rwd_p0;
   logic [4:0]               rs_p0;
   logic [4:0]               rt_p0;
   logic [2:0]               ld_rs_p0;
   logic [2:0]               ld_rt_p0;
   logic signed [DATA_W-1:0] op_a_p0;
   logic signed [DATA_W-1:0] op_b_p0;
   logic signed [DATA_W-1:0] imm_p0;

   // Sign-extend the instruction immediate field to operand width.
   function automatic logic signed [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   // Operand priority: load forward, then r0 constant, then (optional) wb bypass, then RF.
   function automatic logic signed [DATA_W-1:0] select_operand(
      input logic [2:0]        code,
      input logic [4:0]        idx,
      input logic [DATA_W-1:0] rf_val,
      input logic              we,
      input logic [4:0]        waddr,
      input logic [DATA_W-1:0] wdata,
      input logic [DATA_W-1:0] ld_data
   );
      logic signed [DATA_W-1:0] res;
      res = rf_val;
      if (code == LD_FWD_MEM) begin
         res = ld_data;
      end else if (idx == 5'd0) begin
         res = '0;
      end else begin
`ifdef ID_WB_BYPASS_EN
         if (we && (waddr == idx)) res = wdata;
`else
         if (we && (waddr == idx) && 1'b0) res = wdata;
`endif
      end
      return res;
   endfunction

   // Decode fields and pick operands for the instruction being captured.
   always_comb begin
      opcode_p0 = instr_in[31:26];
      bubble_p0 = (opcode_p0 == OP_STALL) || ex_kill;
      no_rwd_p0 = (opcode_p0 == OP_SDW) || (opcode_p0 == OP_BEQ) || (opcode_p0 == OP_JUMP);
      rt_hi_p0  = (opcode_p0 == OP_SDW) || (opcode_p0 == OP_BEQ) || (opcode_p0 == OP_LDW);
      rwd_p0    = no_rwd_p0 ? 5'd0 : instr_in[25:21];
      rs_p0     = instr_in[20:16];
      rt_p0     = rt_hi_p0 ? instr_in[25:21] : instr_in[15:11];
      // Fetch reports 0 for JUMP already; masking here keeps a stray code harmless.
      ld_rs_p0  = (opcode_p0 == OP_JUMP) ? 3'd0 : ld_rs;
      ld_rt_p0  = (opcode_p0 == OP_JUMP) ? 3'd0 : ld_rt;
      op_a_p0   = select_operand(ld_rs_p0, rs_p0, rf[rs_p0], wb_we, wb_addr, wb_data, mem_ld_data);
      op_b_p0   = select_operand(ld_rt_p0, rt_p0, rf[rt_p0], wb_we, wb_addr, wb_data, mem_ld_data);
      imm_p0    = sign_ext_imm(instr_in[IMM_W-1:0]);
   end

   // Register file: writeback commits regardless of kill; r0 is never written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_we && (wb_addr != 5'd0)) begin
         rf[wb_addr] <= wb_data;
      end
   end

   // ---- stage boundary p0 -> EX bundle ----
   // Capture the operand bundle, or a bubble when stalled or killed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_opcode <= OP_STALL;
         ex_rwd    <= 5'd0;
         ex_op_a   <= '0;
         ex_op_b   <= '0;
         ex_imm    <= '0;
         ex_pc     <= '0;
      end else if (bubble_p0) begin
         ex_valid  <= 1'b0;
         ex_opcode <= OP_STALL;
         ex_rwd    <= 5'd0;
         ex_op_a   <= '0;
         ex_op_b   <= '0;
         ex_imm    <= '0;
         ex_pc     <= pc_in;
      end else begin
         ex_valid  <= 1'b1;
         ex_opcode <= opcode_p0;
         ex_rwd    <= rwd_p0;
         ex_op_a   <= op_a_p0;
         ex_op_b   <= op_b_p0;
         ex_imm    <= imm_p0;
         ex_pc     <= pc_in;
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: reset, load forwarding, rt decode,
// JUMP handling, bubbles/kill, r0 behaviour, wb bypass and back-to-back flow.
module tb_id_operand_stage;

   localparam logic [5:0] OP_STALL = 6'h3F;
   localparam logic [5:0] OP_LDW   = 6'h23;
   localparam logic [5:0] OP_SDW   = 6'h2B;
   localparam logic [5:0] OP_JUMP  = 6'h02;
   localparam logic [5:0] OP_ALU   = 6'h00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr_in, pc_in, mem_ld_data, wb_data;
   logic [2:0]  ld_rs, ld_rt;
   logic        wb_we, ex_kill;
   logic [4:0]  wb_addr;
   logic        ex_valid;
   logic [5:0]  ex_opcode;
   logic [4:0]  ex_rwd;
   logic [31:0] ex_op_a, ex_op_b, ex_imm, ex_pc;

   int checks = 0;
   int errors = 0;

   id_operand_stage #(.DATA_W(32), .IMM_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in),
      .ld_rs(ld_rs), .ld_rt(ld_rt), .mem_ld_data(mem_ld_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_kill(ex_kill),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rwd(ex_rwd),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_pc(ex_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] f25,
                                      input logic [4:0] f20, input logic [15:0] imm);
      return {op, f25, f20, imm};
   endfunction

   // One clock; inputs were set after the previous edge, outputs sampled 1ns after this edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_in = {OP_STALL, 26'd0}; pc_in = 32'd0; ld_rs = 3'd0; ld_rt = 3'd0;
      mem_ld_data = 32'd0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; ex_kill = 1'b0;
   endtask

   task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
      idle_inputs();
      wb_we = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_we = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rf_write(5'd5, 32'h1234);
      // Mid-stream reset with a valid instruction and a wb write to r5.
      rst_n = 1'b0;
      instr_in = mk(OP_ALU, 5'd9, 5'd5, 16'h0000); pc_in = 32'h88;
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
      step();
      rst_n = 1'b1;
      checks++;
      if (ex_valid !== 1'b0 || ex_opcode !== OP_STALL || ex_rwd !== 5'd0) begin
         errors++;
         $display("FAIL reset_ctrl got v=%b op=%h rwd=%0d exp v=0 op=%h rwd=0", ex_valid, ex_opcode, ex_rwd, OP_STALL);
      end
      checks++;
      if (ex_op_a !== 32'd0 || ex_op_b !== 32'd0 || ex_imm !== 32'd0 || ex_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_data got a=%h b=%h imm=%h pc=%h exp all 0", ex_op_a, ex_op_b, ex_imm, ex_pc);
      end
      idle_inputs();
      instr_in = mk(OP_ALU, 5'd9, 5'd5, 16'h0000); pc_in = 32'h10;
      step();
      checks++;
      if (ex_op_a !== 32'd0 || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_r5_cleared got a=%h v=%b exp a=0 v=1", ex_op_a, ex_valid);
      end
   endtask

   task automatic test_load_fwd();
      rf_write(5'd3, 32'h11);
      idle_inputs();
      instr_in = mk(OP_ALU, 5'd9, 5'd3, 16'h2000); pc_in = 32'h20;
      ld_rs = 3'd2; mem_ld_data = 32'hABCD;
      step();
      checks++;
      if (ex_op_a !== 32'hABCD || ex_valid !== 1'b1 || ex_rwd !== 5'd9) begin
         errors++;
         $display("FAIL ld_fwd_rs got a=%h v=%b rwd=%0d exp a=0000abcd v=1 rwd=9", ex_op_a, ex_valid, ex_rwd);
      end
      checks++;
      if (ex_op_b !== 32'd0 || ex_imm !== 32'h2000 || ex_pc !== 32'h20 || ex_opcode !== OP_ALU) begin
         errors++;
         $display("FAIL ld_fwd_rest got b=%h imm=%h pc=%h op=%h exp b=0 imm=2000 pc=20 op=0", ex_op_b, ex_imm, ex_pc, ex_opcode);
      end
      // Code 3 means no forward; rt forwarded with code 2.
      ld_rs = 3'd3; ld_rt = 3'd2; mem_ld_data = 32'h5A5A;
      step();
      checks++;
      if (ex_op_a !== 32'h11 || ex_op_b !== 32'h5A5A) begin
         errors++;
         $display("FAIL ld_code3_rt2 got a=%h b=%h exp a=11 b=5a5a", ex_op_a, ex_op_b);
      end
   endtask

   task automatic test_rt_decode();
      rf_write(5'd7, 32'h55);
      idle_inputs();
      instr_in = mk(OP_SDW, 5'd7, 5'd3, 16'hFFF0); pc_in = 32'h30;
      step();
      checks++;
      if (ex_op_b !== 32'h55 || ex_rwd !== 5'd0 || ex_op_a !== 32'h11 || ex_imm !== 32'hFFFFFFF0) begin
         errors++;
         $display("FAIL sdw_decode got b=%h rwd=%0d a=%h imm=%h exp b=55 rwd=0 a=11 imm=fffffff0", ex_op_b, ex_rwd, ex_op_a, ex_imm);
      end
      instr_in = mk(OP_LDW, 5'd7, 5'd3, 16'h0004);
      step();
      checks++;
      if (ex_op_b !== 32'h55 || ex_rwd !== 5'd7 || ex_imm !== 32'h4) begin
         errors++;
         $display("FAIL ldw_decode got b=%h rwd=%0d imm=%h exp b=55 rwd=7 imm=4", ex_op_b, ex_rwd, ex_imm);
      end
   endtask

   task automatic test_jump();
      idle_inputs();
      instr_in = mk(OP_JUMP, 5'd9, 5'd3, 16'h0000); pc_in = 32'h40;
      ld_rs = 3'd2; mem_ld_data = 32'hBAD0;
      step();
      checks++;
      if (ex_op_a !== 32'h11 || ex_rwd !== 5'd0 || ex_valid !== 1'b1 || ex_opcode !== OP_JUMP) begin
         errors++;
         $display("FAIL jump got a=%h rwd=%0d v=%b op=%h exp a=11 rwd=0 v=1 op=02", ex_op_a, ex_rwd, ex_valid, ex_opcode);
      end
   endtask

   task automatic test_bubble_kill();
      idle_inputs();
      instr_in = {OP_STALL, 5'd9, 5'd3, 16'h1234}; pc_in = 32'h50;
      step();
      checks++;
      if (ex_valid !== 1'b0 || ex_opcode !== OP_STALL || ex_pc !== 32'h50 || ex_op_a !== 32'd0 || ex_imm !== 32'd0) begin
         errors++;
         $display("FAIL stall_bubble got v=%b op=%h pc=%h a=%h imm=%h exp v=0 op=3f pc=50 a=0 imm=0", ex_valid, ex_opcode, ex_pc, ex_op_a, ex_imm);
      end
      instr_in = mk(OP_ALU, 5'd9, 5'd3, 16'h3800); pc_in = 32'h54;
      ex_kill = 1'b1; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h99;
      step();
      checks++;
      if (ex_valid !== 1'b0 || ex_opcode !== OP_STALL || ex_rwd !== 5'd0 || ex_op_a !== 32'd0 || ex_pc !== 32'h54) begin
         errors++;
         $display("FAIL kill_bubble got v=%b op=%h rwd=%0d a=%h pc=%h exp v=0 op=3f rwd=0 a=0 pc=54", ex_valid, ex_opcode, ex_rwd, ex_op_a, ex_pc);
      end
      idle_inputs();
      instr_in = mk(OP_ALU, 5'd1, 5'd8, 16'h0000);
      step();
      checks++;
      if (ex_op_a !== 32'h99) begin
         errors++;
         $display("FAIL kill_wb_commit got a=%h exp 99", ex_op_a);
      end
   endtask

   task automatic test_r0();
      rf_write(5'd0, 32'hFF);
      idle_inputs();
      instr_in = mk(OP_ALU, 5'd1, 5'd0, 16'h0000);
      step();
      checks++;
      if (ex_op_a !== 32'd0 || ex_op_b !== 32'd0) begin
         errors++;
         $display("FAIL r0_read got a=%h b=%h exp 0 0", ex_op_a, ex_op_b);
      end
      ld_rs = 3'd2; mem_ld_data = 32'h77;
      step();
      checks++;
      if (ex_op_a !== 32'h77) begin
         errors++;
         $display("FAIL r0_ldfwd got a=%h exp 77", ex_op_a);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_a;
`ifdef ID_WB_BYPASS_EN
      exp_a = 32'd9;
`else
      exp_a = 32'd1;
`endif
      rf_write(5'd4, 32'd1);
      idle_inputs();
      instr_in = mk(OP_ALU, 5'd2, 5'd4, 16'h0000);
      wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
      step();
      checks++;
      if (ex_op_a !== exp_a) begin
         errors++;
         $display("FAIL wb_bypass got a=%h exp %h", ex_op_a, exp_a);
      end
      idle_inputs();
      instr_in = mk(OP_ALU, 5'd2, 5'd4, 16'h0000);
      step();
      checks++;
      if (ex_op_a !== 32'd9) begin
         errors++;
         $display("FAIL wb_after got a=%h exp 9", ex_op_a);
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      instr_in = mk(OP_ALU, 5'd10, 5'd7, 16'h1800); pc_in = 32'h100;
      step();
      checks++;
      if (ex_pc !== 32'h100 || ex_op_a !== 32'h55 || ex_op_b !== 32'h11 || ex_rwd !== 5'd10) begin
         errors++;
         $display("FAIL b2b_first got pc=%h a=%h b=%h rwd=%0d exp pc=100 a=55 b=11 rwd=10", ex_pc, ex_op_a, ex_op_b, ex_rwd);
      end
      instr_in = mk(OP_ALU, 5'd11, 5'd8, 16'h8000); pc_in = 32'h101;
      step();
      checks++;
      if (ex_pc !== 32'h101 || ex_op_a !== 32'h99 || ex_imm !== 32'hFFFF8000 || ex_rwd !== 5'd11) begin
         errors++;
         $display("FAIL b2b_second got pc=%h a=%h imm=%h rwd=%0d exp pc=101 a=99 imm=ffff8000 rwd=11", ex_pc, ex_op_a, ex_imm, ex_rwd);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_load_fwd();
      test_rt_decode();
      test_jump();
      test_bubble_kill();
      test_r0();
      test_bypass();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
